fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised successor to the single-cycle fetch stage: decouples PC generation from instruction delivery.
- Issues sequential instruction-memory requests against a variable, in-order memory latency.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them to decode under a valid/ready handshake.
- On a taken branch or jump (next_PC_select), flushes the queue and discards in-flight responses.

Parameters:
ADDRESS_BITS, 16, width of every PC/address signal
RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0
DEPTH, 4, queue entries and max in-flight requests; power of 2, >= 2

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
next_PC_select  in  1  redirect request from decode/execute
target_PC  in  ADDRESS_BITS  redirect target; bits [1:0] ignored, treated as 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDRESS_BITS  fetch address
imem_rsp_valid  in  1  response valid; one per accepted request, in order, no backpressure
imem_rsp_data  in  32  instruction word
inst_valid  out  1  queue head valid
inst_ready  in  1  decode consumes head
inst_PC  out  ADDRESS_BITS  PC of head instruction
instruction  out  32  head instruction word
occupancy  out  clog2(DEPTH)+1  valid entries in queue

Behaviour:
- Registered state: fetch_pc, running, outstanding (0..DEPTH), drop_cnt (0..DEPTH), rsp_pc, queue rd/wr pointers, count.
- Reset asserted (async): fetch_pc=RESET_PC, rsp_pc=RESET_PC, running=0, outstanding=0, drop_cnt=0, count=0, pointers=0.
- Outputs during reset: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_PC=0, instruction=0, occupancy=0.
- running sets on the first clock edge after reset deasserts; first request is offered one cycle after release.
- imem_req_valid = running & !next_PC_select & (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
- Request fire (valid & ready): fetch_pc += 4 (wraps mod 2^ADDRESS_BITS); outstanding += 1.
- Valid may drop without a handshake (redirect cycle). The memory port does not require address stability.
- Response (imem_rsp_valid): outstanding -= 1.
  - drop_cnt > 0: discard the response; drop_cnt -= 1.
  - Otherwise: enqueue {rsp_pc, imem_rsp_data}; rsp_pc += 4.
  - A response with outstanding == 0 is a protocol error: ignore it, leave state unchanged.
- The credit rule guarantees a response never arrives while the queue is full. No overflow path is required.
- Dequeue (inst_valid & inst_ready): rd_ptr += 1, count -= 1.
  - Enqueue and dequeue in the same cycle leave count unchanged.
- inst_valid = (count != 0). inst_PC and instruction come from the head entry, forced to 0 when inst_valid=0. occupancy = count.
- Response-to-output latency: an entry written at edge t is visible at inst_valid from cycle t+1. There is no bypass.
- Redirect (next_PC_select=1 in cycle t), priority over all other events that cycle:
  - No request is issued in cycle t.
  - Any response arriving in cycle t is discarded.
  - Any dequeue in cycle t is void.
  - At edge t: fetch_pc = rsp_pc = {target_PC[ADDRESS_BITS-1:2],2'b00}; count=0; pointers=0.
  - At edge t: drop_cnt = outstanding - imem_rsp_valid, where outstanding includes requests still owed by a previous redirect.
- Back-to-back redirects: each cycle reloads drop_cnt with the same formula, so all stale responses are dropped. The last target wins.
- After a redirect in cycle t: request for the target at cycle t+1 (if ready); earliest inst_valid for the target is t+3 with 1-cycle memory.
- Throughput: with zero-wait memory and inst_ready=1, one instruction per cycle sustained.

Test Plan:
- Reset release, RESET_PC=0x0000, 1-cycle memory, inst_ready=1 -> request addrs 0,4,8,... one per cycle; inst_valid from cycle 3 after release; inst_PC 0,4,8 with matching data; occupancy never exceeds 1.
- inst_ready=0, 1-cycle memory, DEPTH=4 -> exactly 4 requests issued; occupancy=4; imem_req_valid=0 thereafter. inst_ready=1 for one cycle -> exactly one new request.
- 3-cycle memory latency, 3 in flight, redirect to 0x0102 -> next request addr 0x0100. The 3 stale responses are discarded. First inst_PC=0x0100 with the target's data.
- Redirect in the same cycle a response arrives and a dequeue fires -> the response is dropped; the queue is empty next cycle; drop_cnt = outstanding-1.
- Two consecutive redirect cycles, targets 0x0200 then 0x0300, 2 in flight -> no 0x0200 fetch is delivered; first delivered inst_PC=0x0300.
- fetch_pc=0xFFFC with ADDRESS_BITS=16 -> next request addr 0x0000. Also assert reset (low) mid-burst -> all outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch queue: issues sequential instruction-memory requests under a credit limit and
// buffers returned words with their PCs for decode; redirects flush and drop stale responses.
module fetch_queue #(
  parameter int unsigned             ADDRESS_BITS = 16,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
  parameter int unsigned             DEPTH        = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    next_PC_select,
  input  logic [ADDRESS_BITS-1:0] target_PC,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [31:0]             imem_rsp_data,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic [31:0]             instruction,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDRESS_BITS-1:0] PcStep = ADDRESS_BITS'(4);

  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDRESS_BITS-1:0] rsp_pc_q, rsp_pc_d;
  logic                    running_q;
  logic [CntW-1:0]         outstanding_q, outstanding_d;
  logic [CntW-1:0]         drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;

  logic [ADDRESS_BITS-1:0] pc_mem   [DEPTH];
  logic [31:0]             data_mem [DEPTH];

  logic [ADDRESS_BITS-1:0] target_aligned;
  logic [CntW:0]           credit_sum;
  logic                    req_fire;
  logic                    rsp_ok;
  logic                    enq;
  logic                    deq;

  assign target_aligned = target_PC & ~ADDRESS_BITS'(3);

  // Queue entries plus in-flight requests never exceed DEPTH, so responses always fit.
  assign credit_sum     = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = running_q & ~next_PC_select & (credit_sum < (CntW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok = imem_rsp_valid & (outstanding_q != '0);
  assign enq    = rsp_ok & ~next_PC_select & (drop_cnt_q == '0);
  assign deq    = inst_valid & inst_ready & ~next_PC_select;

  assign inst_valid  = (count_q != '0);
  assign inst_PC     = inst_valid ? pc_mem[rd_ptr_q] : '0;
  assign instruction = inst_valid ? data_mem[rd_ptr_q] : '0;
  assign occupancy   = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_ok);

    if (next_PC_select) begin
      fetch_pc_d = target_aligned;
      rsp_pc_d   = target_aligned;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // Every response still owed, including those of earlier redirects, is stale.
      drop_cnt_d = outstanding_q - CntW'(rsp_ok);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PcStep;
      if (rsp_ok && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
      if (enq) begin
        rsp_pc_d = rsp_pc_q + PcStep;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CntW'(enq) - CntW'(deq);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      running_q     <= 1'b0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      running_q     <= 1'b1;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      pc_mem[wr_ptr_q]   <= rsp_pc_q;
      data_mem[wr_ptr_q] <= imem_rsp_data;
    end
  end

endmodule
